// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register with stall/bubble handling and exception draining.
// Optional build macro FD_PERF_CNT_EN adds saturating stall/bubble/instruction counters.
module fd_pipe_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [3:0]  f_rA,
    input  logic [3:0]  f_rB,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic [1:0]  f_stat,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        squash_exc,
    input  logic [1:0]  wb_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [1:0]  D_stat,
    output logic        D_valid,
    output logic        proc_halted,
    output logic [1:0]  halt_code,
    output logic        ctl_err,
    output logic [1:0]  dbg_state
`ifdef FD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_inst_cnt
`endif
);

    localparam logic [1:0] STAT_AOK  = 2'b00;
    localparam logic [3:0] NOP_ICODE = 4'h1;
    localparam logic [3:0] NO_REG    = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] halt_code_nxt;
    logic       ctl_err_nxt;
    logic       do_load;
    logic       do_bubble;
    logic       drain_forced;
    logic       active;

    // A squash on a DRAIN edge lifts the forced bubble for that same edge.
    always_comb begin
        active       = (state != ST_HALTED);
        drain_forced = (state == ST_DRAIN) && !squash_exc;
        do_load      = 1'b0;
        do_bubble    = 1'b0;
        if (active && !D_stall) begin
            if (D_bubble || drain_forced) begin
                do_bubble = 1'b1;
            end else begin
                do_load = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        halt_code_nxt = halt_code;
        ctl_err_nxt   = ctl_err;
        if (active) begin
            if (D_stall && D_bubble) begin
                ctl_err_nxt = 1'b1;
            end
            case (state)
                ST_RUN: begin
                    if (wb_stat != STAT_AOK) begin
                        state_nxt     = ST_HALTED;
                        halt_code_nxt = wb_stat;
                    end else if (do_load && (f_stat != STAT_AOK)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (squash_exc) begin
                        state_nxt = (do_load && (f_stat != STAT_AOK)) ? ST_DRAIN : ST_RUN;
                    end else if (wb_stat != STAT_AOK) begin
                        state_nxt     = ST_HALTED;
                        halt_code_nxt = wb_stat;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            halt_code <= STAT_AOK;
            ctl_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            halt_code <= halt_code_nxt;
            ctl_err   <= ctl_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || do_bubble) begin
            D_icode <= NOP_ICODE;
            D_ifun  <= 4'h0;
            D_rA    <= NO_REG;
            D_rB    <= NO_REG;
            D_valC  <= 64'h0;
            D_valP  <= 64'h0;
            D_stat  <= STAT_AOK;
            D_valid <= 1'b0;
        end else if (do_load) begin
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
            D_stat  <= f_stat;
            D_valid <= 1'b1;
        end
    end

    assign proc_halted = (state == ST_HALTED);
    assign dbg_state   = state;

`ifdef FD_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= 32'd0;
            perf_bubble_cnt <= 32'd0;
            perf_inst_cnt   <= 32'd0;
        end else if (active) begin
            if (D_stall) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
            if (do_bubble) begin
                perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
            end
            if (do_load) begin
                perf_inst_cnt <= sat_inc(perf_inst_cnt);
            end
        end
    end
`endif

endmodule
